// File: rtl/tspi_master.sv
// Trit-serial full-duplex master: shifts a balanced-ternary word out on O_mosi and captures I_miso.
// Optional trailing mod-3 parity trit is enabled with the TSPI_PARITY_EN macro.
module tspi_master #(
  parameter int TRITS = 6,
  parameter int DIV   = 1
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic                 I_req,
  input  logic [2*TRITS-1:0]   I_wdata,
  output logic                 O_busy,
  output logic                 O_done,
  output logic [2*TRITS-1:0]   O_rdata,
  output logic                 O_err,
  output logic                 O_cs_n,
  output logic [1:0]           O_mosi,
  output logic [1:0]           O_sck,
  input  logic [1:0]           I_miso
);

  // state   | meaning
  // IDLE    | link released, waiting for I_req
  // LEAD    | select asserted, first trit presented, sck ZERO
  // LOW     | sck MINUS, current trit on mosi
  // HIGH    | sck PLUS, miso sampled on first cycle, shift at end
  // TRAIL   | sck/mosi ZERO, select still asserted
  // DONE    | one-cycle result strobe
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_TRAIL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] T_ZERO  = 2'b00;
  localparam logic [1:0] T_PLUS  = 2'b01;
  localparam logic [1:0] T_MINUS = 2'b10;

`ifdef TSPI_PARITY_EN
  localparam int NT = TRITS + 1;
`else
  localparam int NT = TRITS;
`endif
  localparam int CW = $clog2(NT + 1);
  localparam int TW = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(NT - 1);

  function automatic logic [1:0] trit_clean(input logic [1:0] t);
    return (t == 2'b11) ? T_ZERO : t;
  endfunction

`ifdef TSPI_PARITY_EN
  // Residue arithmetic mod 3 with MINUS treated as 2; invalid trits count as ZERO.
  function automatic logic [1:0] m3_add(input logic [1:0] acc, input logic [1:0] t);
    logic [2:0] s;
    s = {1'b0, acc} + ((t == T_PLUS) ? 3'd1 : (t == T_MINUS) ? 3'd2 : 3'd0);
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction
`endif

  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*NT-1:0]   tx_q, tx_d;
  logic [2*TRITS-1:0] rx_q, rx_d;
  logic              inv_q, inv_d;
  logic [2*TRITS-1:0] rdata_d;
  logic              err_d;
  logic              busy_d, done_d, cs_n_d;
  logic [1:0]        mosi_d, sck_d;
  logic              tc;
  logic              par_bad;
`ifdef TSPI_PARITY_EN
  logic [1:0]        par_q, par_d;
  logic [1:0]        wsum;
  logic [1:0]        ptrit;
`endif

  assign tc = (tmr_q == '0);

`ifdef TSPI_PARITY_EN
  always_comb begin
    wsum = 2'd0;
    for (int i = 0; i < TRITS; i++) begin
      wsum = m3_add(wsum, I_wdata[2*i +: 2]);
    end
    ptrit = (wsum == 2'd1) ? T_MINUS : (wsum == 2'd2) ? T_PLUS : T_ZERO;
  end
  assign par_bad = (par_q != 2'd0);
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    inv_d   = inv_q;
    rdata_d = O_rdata;
    err_d   = O_err;
`ifdef TSPI_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (I_req) begin
          state_d = S_LEAD;
          tmr_d   = TMR_LOAD;
          cnt_d   = '0;
`ifdef TSPI_PARITY_EN
          tx_d    = {I_wdata, ptrit};
          par_d   = 2'd0;
`else
          tx_d    = I_wdata;
`endif
          rx_d    = '0;
          inv_d   = 1'b0;
        end
      end
      S_LEAD: begin
        if (tc) begin
          state_d = S_LOW;
          tmr_d   = TMR_LOAD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_LOW: begin
        if (tc) begin
          state_d = S_HIGH;
          tmr_d   = TMR_LOAD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_HIGH: begin
        if (tmr_q == TMR_LOAD) begin
          inv_d = inv_q | (I_miso == 2'b11);
`ifdef TSPI_PARITY_EN
          par_d = m3_add(par_q, I_miso);
          if (cnt_q != CNT_LAST) rx_d = {rx_q[2*TRITS-3:0], trit_clean(I_miso)};
`else
          rx_d  = {rx_q[2*TRITS-3:0], trit_clean(I_miso)};
`endif
        end
        if (tc) begin
          tx_d    = {tx_q[2*NT-3:0], 2'b00};
          cnt_d   = cnt_q + CW'(1);
          tmr_d   = TMR_LOAD;
          state_d = (cnt_q == CNT_LAST) ? S_TRAIL : S_LOW;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_TRAIL: begin
        if (tc) begin
          state_d = S_DONE;
          rdata_d = rx_q;
          err_d   = inv_q | par_bad;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight out of flops.
    busy_d = (state_d inside {S_LEAD, S_LOW, S_HIGH, S_TRAIL});
    cs_n_d = ~busy_d;
    done_d = (state_d == S_DONE);
    sck_d  = (state_d == S_LOW) ? T_MINUS : (state_d == S_HIGH) ? T_PLUS : T_ZERO;
    mosi_d = (state_d inside {S_LEAD, S_LOW, S_HIGH}) ? trit_clean(tx_d[2*NT-1 -: 2]) : T_ZERO;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      inv_q   <= 1'b0;
`ifdef TSPI_PARITY_EN
      par_q   <= 2'd0;
`endif
      O_busy  <= 1'b0;
      O_done  <= 1'b0;
      O_rdata <= '0;
      O_err   <= 1'b0;
      O_cs_n  <= 1'b1;
      O_mosi  <= T_ZERO;
      O_sck   <= T_ZERO;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      inv_q   <= inv_d;
`ifdef TSPI_PARITY_EN
      par_q   <= par_d;
`endif
      O_busy  <= busy_d;
      O_done  <= done_d;
      O_rdata <= rdata_d;
      O_err   <= err_d;
      O_cs_n  <= cs_n_d;
      O_mosi  <= mosi_d;
      O_sck   <= sck_d;
    end
  end

endmodule

// File: tb/tb_tspi_master.sv
// Bench for tspi_master: one DIV=0 and one DIV=2 instance checked against a trit-level model.
module tb_tspi_master;
  localparam int T  = 6;
  localparam int H0 = 1;
  localparam int H1 = 3;
`ifdef TSPI_PARITY_EN
  localparam int NT = T + 1;
`else
  localparam int NT = T;
`endif

  logic             clk;
  logic             rst_n;
  logic             req   [2];
  logic [2*T-1:0]   wdata [2];
  logic             busy  [2];
  logic             done  [2];
  logic [2*T-1:0]   rdata [2];
  logic             err   [2];
  logic             cs_n  [2];
  logic [1:0]       mosi  [2];
  logic [1:0]       sck   [2];
  logic [1:0]       miso  [2];

  int total = 0;
  int bad   = 0;

  tspi_master #(.TRITS(T), .DIV(0)) u_fast (
    .I_clk(clk), .I_rst_n(rst_n), .I_req(req[0]), .I_wdata(wdata[0]),
    .O_busy(busy[0]), .O_done(done[0]), .O_rdata(rdata[0]), .O_err(err[0]),
    .O_cs_n(cs_n[0]), .O_mosi(mosi[0]), .O_sck(sck[0]), .I_miso(miso[0])
  );

  tspi_master #(.TRITS(T), .DIV(2)) u_slow (
    .I_clk(clk), .I_rst_n(rst_n), .I_req(req[1]), .I_wdata(wdata[1]),
    .O_busy(busy[1]), .O_done(done[1]), .O_rdata(rdata[1]), .O_err(err[1]),
    .O_cs_n(cs_n[1]), .O_mosi(mosi[1]), .O_sck(sck[1]), .I_miso(miso[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] clean(input logic [1:0] t);
    return (t == 2'b11) ? 2'b00 : t;
  endfunction

  function automatic int tval(input logic [1:0] t);
    return (t == 2'b01) ? 1 : (t == 2'b10) ? -1 : 0;
  endfunction

  function automatic logic [1:0] rnd_trit();
    return ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
  endfunction

  // r holds the peripheral's return trits in send order: trit k at r[2k+1:2k].
  task automatic xfer(input string name, input int u, input logic [2*T-1:0] w,
                      input logic [2*NT-1:0] r_in, input bit lb, input int pulse);
    int h, done_c, j, run, mosi_bad, phase_bad, cs_bad, s, r3, busy_len;
    logic [1:0] prev_sck, cur_trit, cur_sck;
    logic [2*NT-1:0] seen_mosi, exp_mosi, r;
    logic [2*T-1:0] exp_rd, got_rd;
    logic exp_err, got_err;
    h = (u == 0) ? H0 : H1;
    busy_len = (2 + 2*NT) * h;
    exp_mosi = '0;
    s = 0;
    for (int k = 0; k < T; k++) begin
      exp_mosi[2*(NT-1-k) +: 2] = clean(w[2*(T-1-k) +: 2]);
      s += tval(w[2*(T-1-k) +: 2]);
    end
`ifdef TSPI_PARITY_EN
    r3 = ((s % 3) + 3) % 3;
    exp_mosi[1:0] = (r3 == 0) ? 2'b00 : (r3 == 1) ? 2'b10 : 2'b01;
`endif
    r = r_in;
    if (lb) for (int k = 0; k < NT; k++) r[2*k +: 2] = exp_mosi[2*(NT-1-k) +: 2];
    exp_rd = '0;
    exp_err = 1'b0;
    s = 0;
    for (int k = 0; k < NT; k++) begin
      if (k < T) exp_rd[2*(T-1-k) +: 2] = clean(r[2*k +: 2]);
      if (r[2*k +: 2] == 2'b11) exp_err = 1'b1;
      s += tval(r[2*k +: 2]);
    end
`ifdef TSPI_PARITY_EN
    if ((((s % 3) + 3) % 3) != 0) exp_err = 1'b1;
`endif
    done_c = -1; j = 0; run = 0; mosi_bad = 0; phase_bad = 0; cs_bad = 0;
    prev_sck = 2'b00; cur_trit = 2'b00; seen_mosi = '0; got_rd = '0; got_err = 1'b0;
    @(negedge clk);
    req[u] = 1'b1;
    wdata[u] = w;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      req[u] = (c == pulse);
      cur_sck = sck[u];
      if (cur_sck == 2'b10 && prev_sck != 2'b10) begin
        j++;
        seen_mosi = {seen_mosi[2*NT-3:0], mosi[u]};
        cur_trit = mosi[u];
        if (!lb && j <= NT) miso[u] = r[2*(j-1) +: 2];
      end
      if (lb) miso[u] = mosi[u];
      if (cur_sck == prev_sck) run++;
      else begin
        if (prev_sck != 2'b00 && run != h) phase_bad++;
        run = 1;
      end
      if (cur_sck == 2'b01 && mosi[u] != cur_trit) mosi_bad++;
      if (c <= busy_len && (busy[u] !== 1'b1 || cs_n[u] !== 1'b0)) cs_bad++;
      prev_sck = cur_sck;
      if (done[u] === 1'b1) begin
        done_c = c;
        got_rd = rdata[u];
        got_err = err[u];
        if (busy[u] !== 1'b0 || cs_n[u] !== 1'b1) cs_bad++;
        break;
      end
    end
    req[u] = 1'b0;
    miso[u] = 2'b00;
    check({name, ".done_cycle"}, 64'(done_c), 64'(busy_len + 1));
    check({name, ".mosi_seq"}, 64'(seen_mosi), 64'(exp_mosi));
    check({name, ".trit_count"}, 64'(j), 64'(NT));
    check({name, ".rdata"}, 64'(got_rd), 64'(exp_rd));
    check({name, ".err"}, 64'(got_err), 64'(exp_err));
    check({name, ".phase_len_bad"}, 64'(phase_bad), 64'd0);
    check({name, ".mosi_move_in_plus"}, 64'(mosi_bad), 64'd0);
    check({name, ".busy_cs_bad"}, 64'(cs_bad), 64'd0);
  endtask

  initial begin
    logic [2*T-1:0]  w;
    logic [2*NT-1:0] r;
    int d1, d2, b_idle, b_acc, cnt, entries, extra;
    logic [1:0] prev;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; wdata[u] = '0; miso[u] = 2'b00;
    end
    repeat (3) @(negedge clk);
    check("rst.cs_n", 64'(cs_n[0]), 64'd1);
    check("rst.sck", 64'(sck[0]), 64'd0);
    check("rst.mosi", 64'(mosi[0]), 64'd0);
    check("rst.busy", 64'(busy[0]), 64'd0);
    check("rst.done", 64'(done[0]), 64'd0);
    check("rst.rdata", 64'(rdata[0]), 64'd0);
    check("rst.err", 64'(err[0]), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    xfer("loop612", 0, 12'h612, '0, 1'b1, 0);

    w = 12'(64'($urandom));
    r = '0;
    for (int k = 0; k < NT; k++) r[2*k +: 2] = 2'($urandom_range(0, 2));
    r[5:4] = 2'b11;
    xfer("bad_miso", 0, w, r, 1'b0, 0);
    check("bad_miso.rdata76", 64'(rdata[0][7:6]), 64'd0);

    xfer("div2_loop", 1, 12'h612, '0, 1'b1, 0);
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < T; k++) w[2*k +: 2] = rnd_trit();
      for (int k = 0; k < NT; k++) r[2*k +: 2] = rnd_trit();
      xfer("div2_rand", 1, w, r, 1'b0, 0);
    end

    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < T; k++) w[2*k +: 2] = rnd_trit();
      for (int k = 0; k < NT; k++) r[2*k +: 2] = rnd_trit();
      xfer("rand", 0, w, r, n[0], (n == 3) ? 5 : 0);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy[0] !== 1'b0) extra++;
    end
    check("pulse_ignored.idle", 64'(extra), 64'd0);

`ifdef TSPI_PARITY_EN
    xfer("parity_bad", 0, {T{2'b01}}, {NT{2'b01}}, 1'b0, 0);
`endif

    // Request held high across two transfers.
    d1 = -1; d2 = -1; b_idle = -1; b_acc = -1;
    @(negedge clk);
    req[0] = 1'b1;
    wdata[0] = 12'(64'($urandom));
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (d1 > 0 && c == d1 + 1) b_idle = int'(busy[0]);
      if (d1 > 0 && c == d1 + 2) b_acc = int'(busy[0]);
      if (done[0] === 1'b1) begin
        if (d1 < 0) d1 = c;
        else begin
          d2 = c;
          break;
        end
      end
    end
    req[0] = 1'b0;
    check("b2b.first_done", 64'(d1), 64'((2 + 2*NT) * H0 + 1));
    check("b2b.period", 64'(d2 - d1), 64'((2 + 2*NT) * H0 + 2));
    check("b2b.idle_gap", 64'(b_idle), 64'd0);
    check("b2b.reaccept", 64'(b_acc), 64'd1);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy[0] !== 1'b0) extra++;
    end
    check("b2b.stop", 64'(extra), 64'd0);

    // Reset during the fourth trit.
    entries = 0;
    prev = 2'b00;
    @(negedge clk);
    req[0] = 1'b1;
    wdata[0] = 12'h555;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      req[0] = 1'b0;
      if (sck[0] == 2'b10 && prev != 2'b10) entries++;
      prev = sck[0];
      if (entries == 4) break;
    end
    check("rstmid.reached", 64'(entries), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.cs_n", 64'(cs_n[0]), 64'd1);
    check("rstmid.sck", 64'(sck[0]), 64'd0);
    check("rstmid.busy", 64'(busy[0]), 64'd0);
    check("rstmid.rdata", 64'(rdata[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) cnt++;
    end
    check("rstmid.no_done", 64'(cnt), 64'd0);
    check("rstmid.rdata_after", 64'(rdata[0]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
